// File: rtl/pwm_cfg_pkg.sv
// rtl/pwm_cfg_pkg.sv - shared constants and FSM state type for the PWM config slave
package pwm_cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/spi_pwm_config_if.sv
// rtl/spi_pwm_config_if.sv - SPI pin bundle between pad ring and config slave
interface spi_pwm_config_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rise/fall detection on the synced level
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_dly  <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/spi_pwm_config.sv
// rtl/spi_pwm_config.sv - SPI mode-0 write-only slave owning the five PWM control registers
module spi_pwm_config
  import pwm_cfg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_pwm_config_if.slave     spi,
  output logic [7:0]          en_reg_out_7_0,
  output logic [7:0]          en_reg_out_15_8,
  output logic [7:0]          en_reg_pwm_7_0,
  output logic [7:0]          en_reg_pwm_15_8,
  output logic [7:0]          pwm_duty_cycle,
  output logic                wr_pulse
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_copi_q, w_copi_rise, w_copi_fall;
  logic w_ncs_q,  w_ncs_rise,  w_ncs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(spi.sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_d(spi.copi),
    .o_q(w_copi_q), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  // chip select idles high, so its chain resets to 1 to avoid a false falling edge
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_d(spi.ncs),
    .o_q(w_ncs_q), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  logic w_unused;
  assign w_unused = ^{w_sclk_q, w_sclk_fall, w_copi_rise, w_copi_fall, w_ncs_q};

  state_t      r_state;
  logic [15:0] r_shift;
  logic [4:0]  r_cnt;
  logic [7:0]  r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;
  logic        r_wr_pulse;

  logic [6:0]  w_addr;
  logic        w_frame_ok;

  assign w_addr     = r_shift[14:8];
  assign w_frame_ok = (r_cnt == CNT_FULL) && r_shift[15] && (w_addr <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_en_out_lo <= '0;
      r_en_out_hi <= '0;
      r_en_pwm_lo <= '0;
      r_en_pwm_hi <= '0;
      r_duty      <= '0;
      r_wr_pulse  <= 1'b0;
    end else begin
      r_wr_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ncs_fall) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // chip-select release takes priority over a coincident sclk edge
          if (w_ncs_rise) begin
            r_state <= ST_COMMIT;
          end else if (w_sclk_rise && (r_cnt != CNT_FULL)) begin
            r_shift <= {r_shift[14:0], w_copi_q};
            r_cnt   <= r_cnt + 5'd1;
          end
        end
        ST_COMMIT: begin
          if (w_frame_ok) begin
            r_wr_pulse <= 1'b1;
            case (w_addr)
              ADDR_EN_OUT_LO: r_en_out_lo <= r_shift[7:0];
              ADDR_EN_OUT_HI: r_en_out_hi <= r_shift[7:0];
              ADDR_EN_PWM_LO: r_en_pwm_lo <= r_shift[7:0];
              ADDR_EN_PWM_HI: r_en_pwm_hi <= r_shift[7:0];
              ADDR_DUTY:      r_duty      <= r_shift[7:0];
              default: ;
            endcase
          end
          // a new frame starting during commit would otherwise lose its edge pulse
          if (w_ncs_fall) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign wr_pulse        = r_wr_pulse;

endmodule

// File: tb/tb_spi_pwm_config.sv
// tb/tb_spi_pwm_config.sv - directed SPI frames with a register-image scoreboard
module tb_spi_pwm_config;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = SYNC_STAGES + 2;
  localparam int LAT         = SYNC_STAGES + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_pwm_config_if spi_if();

  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_pulse;

  spi_pwm_config #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi(spi_if.slave),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .wr_pulse(wr_pulse)
  );

  typedef struct {
    logic [39:0] regs;
    int          rise_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m [5];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_pulses = 0;
  int         n_exp_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] model_regs();
    return {m[4], m[3], m[2], m[1], m[0]};
  endfunction

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wr_pulse) begin
      n_pulses++;
      if (sb.size() == 0) begin
        check("sb_entry_on_pulse", 40'(sb.size()), 40'd1);
      end else begin
        e = sb.pop_front();
        check("regs_on_pulse", dut_regs(), e.regs);
        check("ncs_to_update_latency", 40'(cyc - e.rise_cyc), 40'(LAT));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    spi_if.copi = b;
    wait_clks(HALF);
    spi_if.sclk = 1'b1;
    wait_clks(HALF);
    spi_if.sclk = 1'b0;
  endtask

  task automatic send(input logic [31:0] data, input int nbits, input int gap);
    logic [15:0] fr;
    exp_t        e;
    spi_if.ncs = 1'b0;
    wait_clks(HALF);
    for (int i = nbits - 1; i >= 0; i--) bit_out(data[i]);
    wait_clks(HALF);
    spi_if.ncs = 1'b1;
    if (nbits >= 16) begin
      fr = 16'(data >> (nbits - 16));
      if (fr[15] && (int'(fr[14:8]) <= 4)) begin
        m[int'(fr[14:8])] = fr[7:0];
        e.regs     = model_regs();
        e.rise_cyc = cyc;
        sb.push_back(e);
        n_exp_pulses++;
      end
    end
    wait_clks(gap);
  endtask

  initial begin
    spi_if.ncs  = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.copi = 1'b0;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    wait_clks(5);
    check("reset_regs", dut_regs(), 40'h0);
    check("reset_wr_pulse", 40'(wr_pulse), 40'h0);
    rst_n = 1'b1;
    wait_clks(5);

    // abort a frame after 8 bits with reset
    spi_if.ncs = 1'b0;
    wait_clks(HALF);
    for (int i = 7; i >= 0; i--) bit_out(i[0]);
    rst_n = 1'b0;
    spi_if.ncs = 1'b1;
    wait_clks(3);
    check("midframe_reset_regs", dut_regs(), 40'h0);
    check("midframe_reset_pulse", 40'(wr_pulse), 40'h0);
    rst_n = 1'b1;
    wait_clks(HALF);
    send(32'h8055, 16, 12);
    check("post_reset_write", dut_regs(), model_regs());

    send(32'h80F0, 16, 10);
    send(32'h810F, 16, 10);
    send(32'h82AA, 16, 10);
    send(32'h8355, 16, 10);
    send(32'h0480, 16, 10);
    send(32'h8480, 16, 10);
    check("all_regs_written", dut_regs(), 40'h80_55_AA_0F_F0);

    send(32'h8512, 16, 10);
    send(32'hFF12, 16, 10);
    check("bad_addr_ignored", dut_regs(), model_regs());

    send(32'h08A1, 12, 10);
    send(32'h8233F, 20, 10);
    check("short_long_frames", dut_regs(), model_regs());

    send(32'h8011, 16, HALF);
    send(32'h8122, 16, HALF);
    send(32'h8344, 16, HALF);
    send(32'h8099, 16, HALF);
    wait_clks(8);
    check("back_to_back", dut_regs(), model_regs());

    for (int i = 0; i < 16; i++) begin
      spi_if.copi = i[0];
      spi_if.sclk = 1'b1;
      wait_clks(HALF);
      spi_if.sclk = 1'b0;
      wait_clks(HALF);
    end
    send(32'h84C8, 16, 12);

    wait_clks(20);
    check("sb_drained", 40'(sb.size()), 40'd0);
    check("pulse_count", 40'(n_pulses), 40'(n_exp_pulses));
    check("final_regs", dut_regs(), model_regs());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
